// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch controller and the instruction fetch unit: control strobes in,
// instruction fields and memory address out.
interface instr_fetch_unit_if;
  logic        ena;
  logic [7:0]  data;
  logic        load_ir;
  logic        inc_pc;
  logic        load_pc;
  logic        fetch;
  logic [2:0]  opcode;
  logic [12:0] ir_addr;
  logic [12:0] pc_addr;
  logic [12:0] addr;
  logic        ir_valid;
  logic        byte_phase;

  // Controller side: drives the strobes and the memory read bus.
  modport master (
    output ena, data, load_ir, inc_pc, load_pc, fetch,
    input  opcode, ir_addr, pc_addr, addr, ir_valid, byte_phase
  );

  // Fetch unit side.
  modport slave (
    input  ena, data, load_ir, inc_pc, load_pc, fetch,
    output opcode, ir_addr, pc_addr, addr, ir_valid, byte_phase
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: 16-bit IR assembled from two byte loads (high first),
// 13-bit program counter, and the address mux feeding program memory.
module instr_fetch_unit (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_unit_if.slave     bus
);

  typedef enum logic {
    HIGH = 1'b0,
    LOW  = 1'b1
  } phase_t;

  phase_t      phase_q;
  phase_t      phase_d;
  logic        valid_q;
  logic        valid_d;
  logic [15:0] ir_q;
  logic [12:0] pc_q;

  logic        capture;

  assign capture = bus.ena & bus.load_ir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= HIGH;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  // Dropping ena abandons a half-loaded instruction so the next capture is a high byte.
  always_comb begin
    phase_d = phase_q;
    valid_d = valid_q;
    if (!bus.ena) begin
      phase_d = HIGH;
      valid_d = 1'b0;
    end else if (bus.load_ir) begin
      case (phase_q)
        HIGH: begin
          phase_d = LOW;
          valid_d = 1'b0;
        end
        LOW: begin
          phase_d = HIGH;
          valid_d = 1'b1;
        end
        default: begin
          phase_d = HIGH;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q <= 16'h0000;
    end else if (capture) begin
      if (phase_q == HIGH) begin
        ir_q[15:8] <= bus.data;
      end else begin
        ir_q[7:0] <= bus.data;
      end
    end
  end

  // A jump uses the operand held before this edge, even if the low byte is being replaced now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= 13'h0000;
    end else if (bus.ena) begin
      if (bus.load_pc) begin
        pc_q <= ir_q[12:0];
      end else if (bus.inc_pc) begin
        pc_q <= pc_q + 13'd1;
      end
    end
  end

  assign bus.opcode     = ir_q[15:13];
  assign bus.ir_addr    = ir_q[12:0];
  assign bus.pc_addr    = pc_q;
  assign bus.addr       = bus.fetch ? pc_q : ir_q[12:0];
  assign bus.ir_valid   = valid_q;
  assign bus.byte_phase = phase_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized control
// sequences compared against a behavioural model of the IR/PC registers.
module tb_instr_fetch_unit;

  logic clk;
  logic rst;

  instr_fetch_unit_if ifu_bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (ifu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference state, kept as plain integers and a 16-bit word.
  logic [15:0] mIr;
  int          mPc;
  bit          mPhase;
  bit          mValid;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mIr    = 16'h0000;
    mPc    = 0;
    mPhase = 0;
    mValid = 0;
  endtask

  // One rising edge of the reference: jump target is the operand before the edge.
  task automatic modelEdge(input bit en, input logic [7:0] d, input bit ldIr,
                           input bit incPc, input bit ldPc);
    int nextPc;
    if (!en) begin
      mPhase = 0;
      mValid = 0;
    end else begin
      nextPc = mPc;
      if (ldPc)       nextPc = int'(mIr[12:0]);
      else if (incPc) nextPc = (mPc + 1) % 8192;
      if (ldIr) begin
        if (mPhase == 0) begin
          mIr[15:8] = d;
          mPhase    = 1;
          mValid    = 0;
        end else begin
          mIr[7:0]  = d;
          mPhase    = 0;
          mValid    = 1;
        end
      end
      mPc = nextPc;
    end
  endtask

  task automatic checkAll(input string tag);
    logic [12:0] expAddr;
    expAddr = ifu_bus.fetch ? 13'(mPc) : mIr[12:0];
    checkOutput({tag, ".opcode"},     32'(ifu_bus.opcode),     32'(mIr[15:13]));
    checkOutput({tag, ".ir_addr"},    32'(ifu_bus.ir_addr),    32'(mIr[12:0]));
    checkOutput({tag, ".pc_addr"},    32'(ifu_bus.pc_addr),    32'(mPc));
    checkOutput({tag, ".addr"},       32'(ifu_bus.addr),       32'(expAddr));
    checkOutput({tag, ".ir_valid"},   32'(ifu_bus.ir_valid),   32'(mValid));
    checkOutput({tag, ".byte_phase"}, 32'(ifu_bus.byte_phase), 32'(mPhase));
  endtask

  // Drive on the falling edge, advance the model at the rising edge, sample just after.
  task automatic applyStimulus(input bit en, input logic [7:0] d, input bit ldIr,
                               input bit incPc, input bit ldPc, input bit fe,
                               input string tag);
    @(negedge clk);
    ifu_bus.ena     = en;
    ifu_bus.data    = d;
    ifu_bus.load_ir = ldIr;
    ifu_bus.inc_pc  = incPc;
    ifu_bus.load_pc = ldPc;
    ifu_bus.fetch   = fe;
    @(posedge clk);
    modelEdge(en, d, ldIr, incPc, ldPc);
    #1;
    checkAll(tag);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "idle");
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".opcode"},     32'(ifu_bus.opcode),     32'h0);
    checkOutput({tag, ".ir_addr"},    32'(ifu_bus.ir_addr),    32'h0);
    checkOutput({tag, ".pc_addr"},    32'(ifu_bus.pc_addr),    32'h0);
    checkOutput({tag, ".addr"},       32'(ifu_bus.addr),       32'h0);
    checkOutput({tag, ".ir_valid"},   32'(ifu_bus.ir_valid),   32'h0);
    checkOutput({tag, ".byte_phase"}, 32'(ifu_bus.byte_phase), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    bit         rEn, rLd, rInc, rJmp, rFe;

    rst             = 1'b0;
    ifu_bus.ena     = 1'b1;
    ifu_bus.data    = 8'hFF;
    ifu_bus.load_ir = 1'b1;
    ifu_bus.inc_pc  = 1'b1;
    ifu_bus.load_pc = 1'b0;
    ifu_bus.fetch   = 1'b1;
    modelReset();

    // Reset holds everything at zero even with active controls and either address select.
    #1;
    checkAllZero("reset_fetch1");
    @(posedge clk);
    #1;
    ifu_bus.fetch = 1'b0;
    #1;
    checkAllZero("reset_fetch0");

    @(negedge clk);
    ifu_bus.load_ir = 1'b0;
    ifu_bus.inc_pc  = 1'b0;
    rst             = 1'b1;
    idle();

    // Two-byte fetch with PC increment on the second byte.
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, "fetch_hi");
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1, 0, 1'b1, "fetch_lo");
    checkOutput("ir_A53C.opcode",  32'(ifu_bus.opcode),   32'h5);
    checkOutput("ir_A53C.ir_addr", 32'(ifu_bus.ir_addr),  32'h053C);
    checkOutput("ir_A53C.pc",      32'(ifu_bus.pc_addr),  32'h0001);
    checkOutput("ir_A53C.valid",   32'(ifu_bus.ir_valid), 32'h1);

    // PC wrap from 1FFF.
    applyStimulus(1'b1, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b1, "wrap_hi");
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, "wrap_lo");
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "wrap_jump");
    checkOutput("wrap_jump.pc", 32'(ifu_bus.pc_addr), 32'h1FFF);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "wrap_inc");
    checkOutput("wrap_inc.pc",   32'(ifu_bus.pc_addr), 32'h0000);
    checkOutput("wrap_inc.addr", 32'(ifu_bus.addr),    32'h0000);

    // Jump beats increment.
    applyStimulus(1'b1, 8'hE1, 1'b1, 1'b0, 1'b0, 1'b0, "jmp_hi");
    applyStimulus(1'b1, 8'h23, 1'b1, 1'b0, 1'b0, 1'b0, "jmp_lo");
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, "jmp_both");
    checkOutput("jmp_both.pc",   32'(ifu_bus.pc_addr), 32'h0123);
    checkOutput("jmp_both.addr", 32'(ifu_bus.addr),    32'h0123);

    // Jump in the same edge as a low-byte capture takes the old operand.
    applyStimulus(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b1, "jmp_cap_hi");
    applyStimulus(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, "jmp_cap_lo");
    checkOutput("jmp_cap.pc", 32'(ifu_bus.pc_addr), 32'h0A23);

    // Abort via ena restarts with a high byte; ena low also blocks inc/jump.
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, "abort_hi");
    applyStimulus(1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, "abort_off");
    applyStimulus(1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, "abort_restart");
    checkOutput("abort.ir_hi", 32'({ifu_bus.opcode, ifu_bus.ir_addr[12:8]}), 32'h7F);
    checkOutput("abort.phase", 32'(ifu_bus.byte_phase), 32'h1);
    checkOutput("abort.valid", 32'(ifu_bus.ir_valid),   32'h0);

    // Asynchronous reset mid-instruction with PC=0010.
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "ar_lo");
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "ar_hi0");
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, "ar_lo10");
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "ar_jump");
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, "ar_hi40");
    checkOutput("ar_pre.pc",    32'(ifu_bus.pc_addr),    32'h0010);
    checkOutput("ar_pre.phase", 32'(ifu_bus.byte_phase), 32'h1);
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    ifu_bus.load_ir = 1'b0;
    ifu_bus.load_pc = 1'b0;
    rst             = 1'b1;
    applyStimulus(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, "post_reset_hi");
    checkOutput("post_reset.ir_hi", 32'({ifu_bus.opcode, ifu_bus.ir_addr[12:8]}), 32'h12);

    // Random interleaving of all controls.
    for (int i = 0; i < 400; i++) begin
      rd   = 8'($urandom);
      rEn  = ($urandom_range(0, 9) != 0);
      rLd  = ($urandom_range(0, 1) == 1);
      rInc = ($urandom_range(0, 2) == 0);
      rJmp = ($urandom_range(0, 5) == 0);
      rFe  = ($urandom_range(0, 1) == 1);
      applyStimulus(rEn, rd, rLd, rInc, rJmp, rFe, "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state SHALL update on the rising edge (the controller drives its controls on the falling edge).
REQ-002 rst  input  1  reset, asynchronous and active-low; asserting it SHALL immediately force every register to its reset value.
REQ-003 ena  input  1  controller enable; low SHALL abort any partial instruction load.
REQ-004 data  input  8  program-memory read bus.
REQ-005 load_ir  input  1  capture one instruction byte from data.
REQ-006 inc_pc  input  1  advance the program counter by one.
REQ-007 load_pc  input  1  load the program counter from the IR operand (jump).
REQ-008 fetch  input  1  address select: 1 = PC, 0 = IR operand.
REQ-009 opcode  output  3  IR[15:13], consumed by the controller.
REQ-010 ir_addr  output  13  IR[12:0], operand address.
REQ-011 pc_addr  output  13  current program counter.
REQ-012 addr  output  13  memory address bus.
REQ-013 ir_valid  output  1  both IR bytes loaded since the last abort or reset.
REQ-014 byte_phase  output  1  0 = next load_ir captures the high byte; 1 = it captures the low byte.

Function
REQ-015 IR SHALL be 16 bits, loaded high byte first, then low byte, from successive load_ir cycles.
REQ-016 Phase 0 with ena=1 and load_ir=1 at a rising edge: IR[15:8]<=data, IR[7:0] unchanged, byte_phase<=1, ir_valid<=0.
REQ-017 Phase 1 with ena=1 and load_ir=1 at a rising edge: IR[7:0]<=data, byte_phase<=0, ir_valid<=1.
REQ-018 load_ir=0: IR, byte_phase and ir_valid SHALL hold; gaps between the two byte loads are permitted.
REQ-019 opcode and ir_addr SHALL be direct register slices of IR, updated in the same edge as the byte capture (zero added latency).
REQ-020 PC SHALL be 13 bits; inc_pc=1 at an edge: PC<=PC+1 modulo 2^13 (1FFF wraps to 0000, no flag).
REQ-021 load_pc=1 at an edge: PC<=ir_addr as held before that edge.
REQ-022 load_pc and inc_pc both high: load_pc SHALL win, and PC SHALL equal the loaded value with no increment.
REQ-023 inc_pc and load_ir in the same cycle (normal second-byte fetch): both SHALL take effect independently in that edge.
REQ-024 load_pc with load_ir in phase 1 in the same edge: PC SHALL take the pre-edge ir_addr, not the newly captured byte.
REQ-025 addr SHALL be combinational: fetch=1 -> pc_addr; fetch=0 -> ir_addr; no registering.
REQ-026 ena=0 at an edge: byte_phase<=0 and ir_valid<=0; IR and PC SHALL hold; load_ir, inc_pc and load_pc SHALL be ignored.
REQ-027 Re-enabling after ena=0 SHALL always restart with a high-byte capture.
REQ-028 The block SHALL hold no other state; the two-state byte-phase FSM (HIGH, LOW) is the only sequencing.

Reset
REQ-029 When rst=0: PC=0000, IR=0000, byte_phase=0, ir_valid=0; hence opcode=0 (HLT), ir_addr=0000, and addr=0000 for either fetch value.
REQ-030 Reset asserted mid-instruction (phase 1) SHALL discard the captured high byte; the first load_ir after release SHALL be treated as a high byte.
REQ-031 Release of rst SHALL take effect cleanly at the next rising edge; no operation SHALL occur on the release edge unless controls are active and rst is high at that edge.

Verification
REQ-032 Reset, then ena=1, load_ir on 2 edges with data A5 then 3C, inc_pc on the second edge -> IR=A53C, opcode=5, ir_addr=053C, pc_addr=0001, ir_valid=1.
REQ-033 PC=1FFF, inc_pc pulse -> pc_addr=0000; with fetch=1, addr=0000.
REQ-034 IR=E123, load_pc and inc_pc together -> pc_addr=0123; with fetch=0, addr=0123.
REQ-035 High byte 40 loaded (byte_phase=1), ena=0 for 1 edge, then load_ir with 7F -> IR[15:8]=7F, byte_phase=1, ir_valid=0.
REQ-036 rst pulsed low asynchronously between edges while byte_phase=1 and PC=0010 -> outputs zero immediately, before any clock edge.
REQ-037 Random interleaving of load_ir, inc_pc, load_pc and ena checked against a reference model; addr checked against the fetch select every cycle.
